// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operand handshake in, result handshake out.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [3:0]       s;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] R;
    logic [WIDTH-1:0] R2;
    logic             of;
    logic             cf;
    logic             equ;
    logic             dz;
    logic             ill;
    logic             busy;

    modport master (
        output in_valid, x, y, s, out_ready,
        input  in_ready, out_valid, R, R2, of, cf, equ, dz, ill, busy
    );

    modport slave (
        input  in_valid, x, y, s, out_ready,
        output in_ready, out_valid, R, R2, of, cf, equ, dz, ill, busy
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus bit-serial shift-add multiply
// and restoring divide, with a valid/ready handshake on both sides.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic        clk,
    input logic        rst_n,
    seq_alu_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_SLL  = 4'b0000;
    localparam logic [3:0] OP_SRA  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0010;
    localparam logic [3:0] OP_MULU = 4'b0011;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1011;
    localparam logic [3:0] OP_SLTU = 4'b1100;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    // control and architected outputs (reset)
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] r2_q, r2_d;
    logic             of_q, of_d;
    logic             cf_q, cf_d;
    logic             equ_q, equ_d;
    logic             dz_q, dz_d;
    logic             ill_q, ill_d;

    // iteration datapath (not reset)
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             equ_pend_q, equ_pend_d;

    logic [WIDTH:0]          add_full, sub_full;
    logic signed [WIDTH-1:0] x_s, y_s;
    logic [SHW-1:0]          sh;
    logic [WIDTH:0]          mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]        iter_hi, iter_lo;

    always_comb begin
        x_s      = bus.x;
        y_s      = bus.y;
        sh       = bus.y[SHW-1:0];
        add_full = {1'b0, bus.x} + {1'b0, bus.y};
        sub_full = {1'b0, bus.x} - {1'b0, bus.y};

        // one multiply step: conditional add into the high half, then shift the pair right
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        // one restoring-divide step: shift in next dividend bit, keep difference if no borrow
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (is_div_q) begin
            iter_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            iter_lo = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        r2_d       = r2_q;
        of_d       = of_q;
        cf_d       = cf_q;
        equ_d      = equ_q;
        dz_d       = dz_q;
        ill_d      = ill_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        equ_pend_d = equ_pend_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.s == OP_MULU || (bus.s == OP_DIVU && bus.y != '0)) begin
                        state_d    = ITER;
                        cnt_d      = '0;
                        hi_d       = '0;
                        lo_d       = bus.x;
                        opnd_d     = bus.y;
                        is_div_d   = (bus.s == OP_DIVU);
                        equ_pend_d = (bus.x == bus.y);
                    end else begin
                        state_d = DONE;
                        r_d     = '0;
                        r2_d    = '0;
                        of_d    = 1'b0;
                        cf_d    = 1'b0;
                        dz_d    = 1'b0;
                        ill_d   = 1'b0;
                        equ_d   = (bus.x == bus.y);
                        case (bus.s)
                            OP_SLL:  r_d = bus.x << sh;
                            OP_SRA:  r_d = x_s >>> sh;
                            OP_SRL:  r_d = bus.x >> sh;
                            OP_DIVU: begin
                                r_d  = '1;
                                r2_d = bus.x;
                                dz_d = 1'b1;
                            end
                            OP_ADD: begin
                                r_d  = add_full[WIDTH-1:0];
                                cf_d = add_full[WIDTH];
                                of_d = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) &&
                                       (add_full[WIDTH-1] != bus.x[WIDTH-1]);
                            end
                            OP_SUB: begin
                                r_d  = sub_full[WIDTH-1:0];
                                cf_d = sub_full[WIDTH];
                                of_d = (bus.x[WIDTH-1] != bus.y[WIDTH-1]) &&
                                       (sub_full[WIDTH-1] != bus.x[WIDTH-1]);
                            end
                            OP_AND:  r_d = bus.x & bus.y;
                            OP_OR:   r_d = bus.x | bus.y;
                            OP_XOR:  r_d = bus.x ^ bus.y;
                            OP_NOR:  r_d = ~(bus.x | bus.y);
                            OP_SLT:  r_d[0] = (x_s < y_s);
                            OP_SLTU: r_d[0] = (bus.x < bus.y);
                            default: ill_d = 1'b1;
                        endcase
                    end
                end
            end
            ITER: begin
                hi_d  = iter_hi;
                lo_d  = iter_lo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    r_d     = iter_lo;
                    r2_d    = iter_hi;
                    of_d    = 1'b0;
                    cf_d    = 1'b0;
                    dz_d    = 1'b0;
                    ill_d   = 1'b0;
                    equ_d   = equ_pend_q;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            r2_q    <= '0;
            of_q    <= 1'b0;
            cf_q    <= 1'b0;
            equ_q   <= 1'b0;
            dz_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            r2_q    <= r2_d;
            of_q    <= of_d;
            cf_q    <= cf_d;
            equ_q   <= equ_d;
            dz_q    <= dz_d;
            ill_q   <= ill_d;
        end
    end

    always_ff @(posedge clk) begin
        hi_q       <= hi_d;
        lo_q       <= lo_d;
        opnd_q     <= opnd_d;
        is_div_q   <= is_div_d;
        equ_pend_q <= equ_pend_d;
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == ITER);
    assign bus.R         = r_q;
    assign bus.R2        = r2_q;
    assign bus.of        = of_q;
    assign bus.cf        = cf_q;
    assign bus.equ       = equ_q;
    assign bus.dz        = dz_q;
    assign bus.ill       = ill_q;
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width (legal 8..64, power of two).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), giving the shift-amount width taken from y[SHW-1:0].
REQ-003 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the request is present.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block can accept a request.
REQ-007 The block SHALL have ports x and y, input, WIDTH each, the operands.
REQ-008 The block SHALL have port s, input, 4, the opcode: 0000 SLL, 0001 SRA, 0010 SRL, 0011 MULU, 0100 DIVU, 0101 ADD, 0110 SUB, 0111 AND, 1000 OR, 1001 XOR, 1010 NOR, 1011 SLT, 1100 SLTU.
REQ-009 The block SHALL have port out_valid, output, 1, meaning the result is present.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-011 The block SHALL have ports R and R2, output, WIDTH each: the low result/quotient and the high product/remainder.
REQ-012 The block SHALL have ports of, cf, equ, dz and ill, output, 1 each: overflow, carry/borrow, x==y, divide-by-zero and illegal opcode.
REQ-013 The block SHALL have port busy, output, 1, high while a multi-cycle op iterates.

Function
REQ-014 The FSM SHALL have states IDLE, ITER and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with in_valid && in_ready.
REQ-016 The block SHALL register x, y and s at acceptance; later input changes SHALL NOT affect the result.
REQ-017 For a single-cycle op (every op except MULU/DIVU), IDLE SHALL go to DONE, with out_valid high on the cycle after acceptance (latency 1).
REQ-018 For MULU/DIVU, IDLE SHALL go to ITER and stay for exactly WIDTH cycles, with out_valid rising WIDTH+1 cycles after acceptance.
REQ-019 MULU SHALL use shift-add, one bit per cycle, producing the unsigned 2*WIDTH product split into {R2,R}.
REQ-020 DIVU SHALL use restoring division, one bit per cycle, with R = quotient and R2 = remainder.
REQ-021 DIVU with y==0 SHALL skip ITER, go to DONE with latency 1, set R = all ones, R2 = x and dz = 1.
REQ-022 ADD SHALL give R = x+y mod 2^WIDTH, cf = carry out of the MSB, and of = (x[MSB]==y[MSB]) && (R[MSB]!=x[MSB]).
REQ-023 SUB SHALL give R = x-y, cf = 1 iff x<y unsigned, and of = (x[MSB]!=y[MSB]) && (R[MSB]!=x[MSB]).
REQ-024 of and cf SHALL be computed from the true result, never from a previous R.
REQ-025 SRA/SRL/SLL SHALL shift by y[SHW-1:0]; SLT/SLTU SHALL return 1 or 0 in R.
REQ-026 For every op other than MULU/DIVU, R2 SHALL be 0; of and cf SHALL be 0 except for ADD/SUB.
REQ-027 equ SHALL be registered with the result: x==y of the accepted operands.
REQ-028 Opcodes 1101-1111 SHALL complete in 1 cycle with R = R2 = 0, of = cf = dz = 0 and ill = 1.
REQ-029 R, R2 and the flags SHALL hold stable while out_valid && !out_ready.
REQ-030 DONE SHALL return to IDLE on out_valid && out_ready; there SHALL be no same-cycle re-accept, so in_ready rises the next cycle.
REQ-031 busy SHALL equal (state==ITER).
REQ-032 Outputs R, R2 and the flags SHALL change only on the transition into DONE.

Reset
REQ-033 rst_n low SHALL immediately set state = IDLE; in_ready = 1; out_valid = busy = 0; R = R2 = 0; and of = cf = equ = dz = ill = 0.
REQ-034 Reset asserted during ITER or DONE SHALL abort the operation with no result delivered.
REQ-035 After release, the first accepted request SHALL behave identically to one issued after power-up.

Verification
REQ-036 ADD with x=0x7FFFFFFF, y=1 -> after 1 cycle R=0x80000000, of=1, cf=0, R2=0.
REQ-037 SUB with x=0, y=1 -> R=0xFFFFFFFF, cf=1, of=0; SUB with x=5, y=5 -> R=0, equ=1.
REQ-038 MULU with x=0xFFFFFFFF, y=0xFFFFFFFF -> out_valid at cycle 33, R2=0xFFFFFFFE, R=0x00000001, busy high for 32 cycles.
REQ-039 DIVU with x=100, y=7 -> cycle 33: R=14, R2=2; DIVU with y=0 and x=9 -> cycle 1: R=0xFFFFFFFF, R2=9, dz=1.
REQ-040 With out_ready held low for 5 cycles after SRA x=0x80000000, y=4 -> R stays 0xF8000000 and in_ready stays 0 until the handshake.
REQ-041 rst_n pulsed low at cycle 10 of a MULU -> out_valid=0, in_ready=1 immediately; a following ADD 2+3 gives R=5.
